// File: rtl/pmod_cls_update_sequencer.sv
// Sequences clear / line1 / line2 commands into the PMOD CLS driver from request pulses or auto-refresh.
// Each phase is a strobe-until-ready-low, then wait-ready-high handshake; requests seen while busy coalesce.
module pmod_cls_update_sequencer #(
   parameter int parm_fast_simulation = 0,
   parameter int FCLK                 = 20000000,
   parameter int parm_refresh_ms      = 500,
   parameter int parm_ack_timeout     = 65535
) (
   input  logic         i_clk_20mhz,
   input  logic         i_rstn_20mhz,
   input  logic         i_req_update,
   input  logic         i_req_clear,
   input  logic         i_auto_refresh_en,
   input  logic [127:0] i_line1,
   input  logic [127:0] i_line2,
   input  logic         i_command_ready,
   output logic         o_cmd_wr_clear_display,
   output logic         o_cmd_wr_text_line1,
   output logic         o_cmd_wr_text_line2,
   output logic [127:0] o_dat_ascii_line1,
   output logic [127:0] o_dat_ascii_line2,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_err_timeout
);

   localparam int REFRESH_CYC = (parm_fast_simulation != 0) ? 100 : (FCLK / 1000) * parm_refresh_ms;
   localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYC - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(parm_ack_timeout - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR_REQ, S_CLR_ACK, S_L1_REQ, S_L1_ACK, S_L2_REQ, S_L2_ACK, S_DONE
   } state_t;

   state_t      state_q;
   logic [31:0] ref_cnt_q, ref_cnt_d;
   logic [31:0] phase_cnt_q;
   logic        pend_upd_q, pend_upd_d;
   logic        pend_clr_q, pend_clr_d;
   logic        refresh_hit;
   logic        take;
   logic        expired;

   assign refresh_hit = i_auto_refresh_en && (ref_cnt_q == REFRESH_LAST);
   assign take        = (state_q == S_IDLE) && (pend_upd_q || pend_clr_q) && i_command_ready;
   assign expired     = (phase_cnt_q == TIMEOUT_LAST);

   // A request landing on the snapshot cycle survives the clear and drives the next pass.
   always_comb begin
      ref_cnt_d = '0;
      if (i_auto_refresh_en && !refresh_hit) ref_cnt_d = ref_cnt_q + 32'd1;
      pend_upd_d = (pend_upd_q && !take) || i_req_update || refresh_hit;
      pend_clr_d = (pend_clr_q && !take) || i_req_clear;
   end

   always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
      if (!i_rstn_20mhz) begin
         state_q                <= S_IDLE;
         ref_cnt_q              <= '0;
         phase_cnt_q            <= '0;
         pend_upd_q             <= 1'b0;
         pend_clr_q             <= 1'b0;
         o_cmd_wr_clear_display <= 1'b0;
         o_cmd_wr_text_line1    <= 1'b0;
         o_cmd_wr_text_line2    <= 1'b0;
         o_dat_ascii_line1      <= '0;
         o_dat_ascii_line2      <= '0;
         o_busy                 <= 1'b0;
         o_done                 <= 1'b0;
         o_err_timeout          <= 1'b0;
      end else begin
         ref_cnt_q   <= ref_cnt_d;
         pend_upd_q  <= pend_upd_d;
         pend_clr_q  <= pend_clr_d;
         o_done      <= 1'b0;
         phase_cnt_q <= phase_cnt_q + 32'd1;
         case (state_q)
            S_IDLE: begin
               phase_cnt_q <= '0;
               if (take) begin
                  o_dat_ascii_line1 <= i_line1;
                  o_dat_ascii_line2 <= i_line2;
                  o_busy            <= 1'b1;
                  if (pend_clr_q) begin
                     state_q                <= S_CLR_REQ;
                     o_cmd_wr_clear_display <= 1'b1;
                  end else begin
                     state_q             <= S_L1_REQ;
                     o_cmd_wr_text_line1 <= 1'b1;
                  end
               end
            end
            S_CLR_REQ: begin
               if (!i_command_ready) begin
                  o_cmd_wr_clear_display <= 1'b0;
                  phase_cnt_q            <= '0;
                  state_q                <= S_CLR_ACK;
               end else if (expired) begin
                  o_cmd_wr_clear_display <= 1'b0;
                  o_err_timeout          <= 1'b1;
                  o_done                 <= 1'b1;
                  state_q                <= S_DONE;
               end
            end
            S_CLR_ACK: begin
               if (i_command_ready) begin
                  o_cmd_wr_text_line1 <= 1'b1;
                  phase_cnt_q         <= '0;
                  state_q             <= S_L1_REQ;
               end else if (expired) begin
                  o_err_timeout <= 1'b1;
                  o_done        <= 1'b1;
                  state_q       <= S_DONE;
               end
            end
            S_L1_REQ: begin
               if (!i_command_ready) begin
                  o_cmd_wr_text_line1 <= 1'b0;
                  phase_cnt_q         <= '0;
                  state_q             <= S_L1_ACK;
               end else if (expired) begin
                  o_cmd_wr_text_line1 <= 1'b0;
                  o_err_timeout       <= 1'b1;
                  o_done              <= 1'b1;
                  state_q             <= S_DONE;
               end
            end
            S_L1_ACK: begin
               if (i_command_ready) begin
                  o_cmd_wr_text_line2 <= 1'b1;
                  phase_cnt_q         <= '0;
                  state_q             <= S_L2_REQ;
               end else if (expired) begin
                  o_err_timeout <= 1'b1;
                  o_done        <= 1'b1;
                  state_q       <= S_DONE;
               end
            end
            S_L2_REQ: begin
               if (!i_command_ready) begin
                  o_cmd_wr_text_line2 <= 1'b0;
                  phase_cnt_q         <= '0;
                  state_q             <= S_L2_ACK;
               end else if (expired) begin
                  o_cmd_wr_text_line2 <= 1'b0;
                  o_err_timeout       <= 1'b1;
                  o_done              <= 1'b1;
                  state_q             <= S_DONE;
               end
            end
            S_L2_ACK: begin
               if (i_command_ready || expired) begin
                  if (!i_command_ready) o_err_timeout <= 1'b1;
                  o_done  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               phase_cnt_q <= '0;
               o_busy      <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmod_cls_update_sequencer.sv
// Bench for pmod_cls_update_sequencer: driver model plus scoreboard of expected strobes and done pulses.
module tb_pmod_cls_update_sequencer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         req_update = 1'b0;
   logic         req_clear = 1'b0;
   logic         auto_en = 1'b0;
   logic [127:0] line1 = '0;
   logic [127:0] line2 = '0;
   logic         ready;
   logic         s_clr, s_l1, s_l2;
   logic [127:0] dat1, dat2;
   logic         busy, done, err;

   pmod_cls_update_sequencer #(
      .parm_fast_simulation(1),
      .FCLK(20000000),
      .parm_refresh_ms(500),
      .parm_ack_timeout(64)
   ) dut (
      .i_clk_20mhz(clk),
      .i_rstn_20mhz(rst_n),
      .i_req_update(req_update),
      .i_req_clear(req_clear),
      .i_auto_refresh_en(auto_en),
      .i_line1(line1),
      .i_line2(line2),
      .i_command_ready(ready),
      .o_cmd_wr_clear_display(s_clr),
      .o_cmd_wr_text_line1(s_l1),
      .o_cmd_wr_text_line2(s_l2),
      .o_dat_ascii_line1(dat1),
      .o_dat_ascii_line2(dat2),
      .o_busy(busy),
      .o_done(done),
      .o_err_timeout(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]   code;   // 0 clear, 1 line1, 2 line2, 3 done
      logic [127:0] l1;
      logic [127:0] l2;
   } ev_t;

   ev_t  sb[$];
   int   l1_times[$];
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   int   cyc = 0;
   logic drv_never = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Driver model: drop ready 3 cycles after seeing a strobe, hold it low 20 cycles.
   int drv_ph = 0;
   int drv_cnt = 0;
   initial begin
      ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n || drv_never) begin
            drv_ph = 0;
            ready  = 1'b1;
         end else begin
            case (drv_ph)
               0: if (s_clr || s_l1 || s_l2) begin drv_cnt = 0; drv_ph = 1; end
               1: begin
                  drv_cnt++;
                  if (drv_cnt == 3) begin ready = 1'b0; drv_cnt = 0; drv_ph = 2; end
               end
               default: begin
                  drv_cnt++;
                  if (drv_cnt == 20) begin ready = 1'b1; drv_ph = 0; end
               end
            endcase
         end
      end
   end

   // Monitor: strobe rises and done pulses are matched against the scoreboard.
   logic [2:0] prev_strb = 3'b0;
   logic       prev_rdy = 1'b1;
   logic [2:0] cur;
   ev_t        mon_e;
   always @(negedge clk) begin
      cur = {s_l2, s_l1, s_clr};
      if (!rst_n) begin
         prev_strb = 3'b0;
         prev_rdy  = ready;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (cur[i] && !prev_strb[i]) begin
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_strobe got code=%0d want=none", i);
               end else begin
                  mon_e = sb.pop_front();
                  if ({mon_e.code, mon_e.l1, mon_e.l2} !== {2'(i), dat1, dat2}) begin
                     bad++;
                     $display("FAIL strobe_event got code=%0d l1=%h l2=%h want code=%0d l1=%h l2=%h",
                              i, dat1, dat2, mon_e.code, mon_e.l1, mon_e.l2);
                  end
               end
               total++;
               if ({ready, cur} !== {1'b1, 3'(1 << i)}) begin
                  bad++;
                  $display("FAIL strobe_start got ready=%b strobes=%b want ready=1 strobes=%b", ready, cur, 3'(1 << i));
               end
               if (i == 1) l1_times.push_back(cyc);
            end
            if (!cur[i] && prev_strb[i]) begin
               total++;
               if (!(prev_rdy == 1'b0 || err == 1'b1)) begin
                  bad++;
                  $display("FAIL strobe_drop got ready_before=%b err=%b want ready_before=0", prev_rdy, err);
               end
            end
         end
         if (done) begin
            done_cnt++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_done got done=1 want none");
            end else begin
               mon_e = sb.pop_front();
               if (mon_e.code !== 2'd3) begin
                  bad++;
                  $display("FAIL done_order got code=3 want code=%0d", mon_e.code);
               end
            end
         end
         prev_strb = cur;
         prev_rdy  = ready;
      end
   end

   task automatic push_pass(input logic clr, input logic [127:0] a, input logic [127:0] b);
      if (clr) sb.push_back({2'd0, a, b});
      sb.push_back({2'd1, a, b});
      sb.push_back({2'd2, a, b});
      sb.push_back({2'd3, a, b});
   endtask

   task automatic pulse_upd();
      @(posedge clk); #1 req_update = 1'b1;
      @(posedge clk); #1 req_update = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n >= budget) begin
         bad++;
         $display("FAIL %s_timeout got pending=%0d busy=%b want pending=0 busy=0", name, sb.size(), busy);
      end
   endtask

   task automatic wait_strobe(input int which, input int budget);
      int n = 0;
      logic s;
      s = (which == 0) ? s_clr : (which == 1) ? s_l1 : s_l2;
      while (!s && n < budget) begin
         @(posedge clk); #1;
         n++;
         s = (which == 0) ? s_clr : (which == 1) ? s_l1 : s_l2;
      end
      total++;
      if (!s) begin
         bad++;
         $display("FAIL wait_strobe%0d got low want high", which);
      end
   endtask

   task automatic test_reset();
      #5 rst_n = 1'b0;
      #1;
      total++;
      if ({s_clr, s_l1, s_l2, busy, done, err} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl got %b want 000000", {s_clr, s_l1, s_l2, busy, done, err});
      end
      total++;
      if ({dat1, dat2} !== 256'b0) begin
         bad++;
         $display("FAIL reset_dat got %h want 0", {dat1, dat2});
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_basic_update();
      int d0 = done_cnt;
      line1 = "HELLO WORLD     ";
      line2 = "ACL TESTER 0001 ";
      push_pass(1'b0, line1, line2);
      pulse_upd();
      wait_idle("basic", 400);
      @(posedge clk); #1;
      total++;
      if ({busy, 32'(done_cnt - d0)} !== {1'b0, 32'd1}) begin
         bad++;
         $display("FAIL basic_done got busy=%b dones=%0d want busy=0 dones=1", busy, done_cnt - d0);
      end
      total++;
      if ({dat1, dat2} !== {line1, line2}) begin
         bad++;
         $display("FAIL basic_dat got %h want %h", {dat1, dat2}, {line1, line2});
      end
   endtask

   task automatic test_clear_update();
      int d0 = done_cnt;
      line2 = "CLEARED LINE TWO";
      push_pass(1'b1, line1, line2);
      @(posedge clk); #1 req_clear = 1'b1;
      @(posedge clk); #1 req_clear = 1'b0;
      wait_idle("clear", 400);
      total++;
      if (done_cnt - d0 !== 1) begin
         bad++;
         $display("FAIL clear_done got %0d want 1", done_cnt - d0);
      end
   endtask

   task automatic test_coalesce();
      int d0 = done_cnt;
      logic [127:0] a1, a2;
      a1 = "FIRST PASS L1   ";
      a2 = "FIRST PASS L2   ";
      line1 = a1;
      line2 = a2;
      push_pass(1'b0, a1, a2);
      pulse_upd();
      wait_strobe(1, 20);
      pulse_upd();
      repeat (2) @(posedge clk);
      pulse_upd();
      #1 line1 = "SECOND PASS L1  ";
      push_pass(1'b0, line1, a2);
      pulse_upd();
      wait_idle("coalesce", 600);
      repeat (20) @(posedge clk);
      #1;
      total++;
      if ({busy, 32'(done_cnt - d0)} !== {1'b0, 32'd2}) begin
         bad++;
         $display("FAIL coalesce_passes got busy=%b dones=%0d want busy=0 dones=2", busy, done_cnt - d0);
      end
   endtask

   task automatic test_auto_refresh();
      int d0 = done_cnt;
      l1_times.delete();
      for (int k = 0; k < 3; k++) push_pass(1'b0, line1, line2);
      @(posedge clk); #1 auto_en = 1'b1;
      repeat (350) @(posedge clk);
      #1 auto_en = 1'b0;
      wait_idle("refresh", 200);
      repeat (300) @(posedge clk);
      #1;
      total++;
      if (done_cnt - d0 !== 3) begin
         bad++;
         $display("FAIL refresh_passes got %0d want 3", done_cnt - d0);
      end
      total++;
      if (l1_times.size() !== 3) begin
         bad++;
         $display("FAIL refresh_starts got %0d want 3", l1_times.size());
      end else begin
         for (int k = 1; k < 3; k++) begin
            total++;
            if (l1_times[k] - l1_times[k-1] !== 100) begin
               bad++;
               $display("FAIL refresh_period got %0d want 100", l1_times[k] - l1_times[k-1]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      int d0 = done_cnt;
      int n = 0;
      drv_never = 1'b1;
      sb.push_back({2'd1, line1, line2});
      sb.push_back({2'd3, line1, line2});
      pulse_upd();
      wait_strobe(1, 20);
      while (s_l1 && n < 200) begin
         n++;
         @(posedge clk); #1;
      end
      total++;
      if (n !== 64) begin
         bad++;
         $display("FAIL timeout_strobe_len got %0d want 64", n);
      end
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL timeout_err got %b want 1", err);
      end
      wait_idle("timeout", 50);
      repeat (20) @(posedge clk);
      #1;
      total++;
      if ({err, s_l2, busy, 32'(done_cnt - d0)} !== {3'b100, 32'd1}) begin
         bad++;
         $display("FAIL timeout_end got err=%b l2=%b busy=%b dones=%0d want err=1 l2=0 busy=0 dones=1",
                  err, s_l2, busy, done_cnt - d0);
      end
      drv_never = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midop();
      int d0;
      sb.push_back({2'd1, line1, line2});
      sb.push_back({2'd2, line1, line2});
      pulse_upd();
      wait_strobe(2, 200);
      pulse_upd();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({s_clr, s_l1, s_l2, busy, done, err, dat1, dat2} !== 262'b0) begin
         bad++;
         $display("FAIL midop_reset got ctrl=%b dat=%h want all 0", {s_clr, s_l1, s_l2, busy, done, err}, {dat1, dat2});
      end
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      d0 = done_cnt;
      repeat (100) @(posedge clk);
      #1;
      total++;
      if ({busy, s_clr, s_l1, s_l2, 32'(done_cnt - d0), 32'(sb.size())} !== 68'b0) begin
         bad++;
         $display("FAIL midop_after got busy=%b strobes=%b dones=%0d pending=%0d want all 0",
                  busy, {s_clr, s_l1, s_l2}, done_cnt - d0, sb.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_update();
      test_clear_update();
      test_coalesce();
      test_auto_refresh();
      test_timeout();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
